// File: rtl/noc_output_arbiter.sv
// Round-robin output arbiter with a one-entry holding register per input and same-cycle refill.
// Optional per-requester grant counters are enabled by defining NOC_ARB_GRANT_COUNT_EN.
package pa_noc;
  parameter int APB_PACKET_WIDTH = 32;
endpackage

module noc_output_arbiter #(
  parameter int GRID_WIDTH = 4,
  parameter int NUM_REQ    = 5
) (
  input  logic                                      i_clk,
  input  logic                                      i_srst,
  input  logic [NUM_REQ*pa_noc::APB_PACKET_WIDTH-1:0] i_req,
  output logic [NUM_REQ-1:0]                        o_ready,
  output logic [pa_noc::APB_PACKET_WIDTH-1:0]       o_packet,
`ifdef NOC_ARB_GRANT_COUNT_EN
  output logic [NUM_REQ*16-1:0]                     o_grantCount,
`endif
  output logic [NUM_REQ-1:0]                        o_grant
);

  localparam int APB_PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [APB_PACKET_WIDTH-1:0] hold [NUM_REQ];
  logic [NUM_REQ-1:0]          full;
  logic [NUM_REQ-1:0]          req_vld;
  logic [NUM_REQ-1:0]          accept;
  logic [NUM_REQ-1:0]          gnt_hot;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            gnt_idx;
  logic                        gnt_vld;
  logic [APB_PACKET_WIDTH-1:0] packet_p1;
  logic [NUM_REQ-1:0]          grant_p1;

  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    int r;
    r = v;
    if (r >= NUM_REQ) r = r - NUM_REQ;
    return r[PTR_W-1:0];
  endfunction

  // Stage p0: pick the first full slot at or after ptr. Scanning downwards lets the
  // closest slot to ptr overwrite any farther candidate.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (full[wrap_idx(int'(ptr) + k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(int'(ptr) + k);
      end
    end
  end

  always_comb begin
    gnt_hot = '0;
    if (gnt_vld) gnt_hot[gnt_idx] = 1'b1;
  end

  // A slot being drained this cycle may be refilled in the same cycle.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign req_vld[i] = |i_req[i*APB_PACKET_WIDTH +: APB_PACKET_WIDTH];
    assign o_ready[i] = !i_srst && (!full[i] || gnt_hot[i]);
    assign accept[i]  = req_vld[i] && o_ready[i];
  end

  // Stage p1: registered grant and control state.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      full      <= '0;
      ptr       <= '0;
      grant_p1  <= '0;
      packet_p1 <= '0;
    end else begin
      full      <= (full & ~gnt_hot) | accept;
      grant_p1  <= gnt_hot;
      packet_p1 <= gnt_vld ? hold[gnt_idx] : '0;
      if (gnt_vld) ptr <= wrap_idx(int'(gnt_idx) + 1);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) hold[i] <= i_req[i*APB_PACKET_WIDTH +: APB_PACKET_WIDTH];
    end
  end

  assign o_packet = packet_p1;
  assign o_grant  = grant_p1;

`ifdef NOC_ARB_GRANT_COUNT_EN
  logic [15:0] gcnt [NUM_REQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_hot[i]) gcnt[i] <= sat_inc(gcnt[i]);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign o_grantCount[i*16 +: 16] = gcnt[i];
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: table of per-cycle vectors plus
// bypass-stream and mid-burst-reset sequences.
module tb_noc_output_arbiter;
  localparam int W = pa_noc::APB_PACKET_WIDTH;
  localparam int N = 5;

  logic             clk = 1'b0;
  logic             srst;
  logic [N*W-1:0]   req;
  logic [N-1:0]     ready;
  logic [W-1:0]     packet;
  logic [N-1:0]     grant;
`ifdef NOC_ARB_GRANT_COUNT_EN
  logic [N*16-1:0]  gcount;
`endif

  int total = 0;
  int bad   = 0;

  noc_output_arbiter #(.GRID_WIDTH(4), .NUM_REQ(N)) dut (
    .i_clk(clk),
    .i_srst(srst),
    .i_req(req),
    .o_ready(ready),
    .o_packet(packet),
`ifdef NOC_ARB_GRANT_COUNT_EN
    .o_grantCount(gcount),
`endif
    .o_grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           srst;
    logic [N*W-1:0] req;
    logic [N-1:0]   ready;
    logic [W-1:0]   pkt;
    logic [N-1:0]   gnt;
  } vec_t;

  vec_t tbl [18];
  int   nvec = 0;

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] l, n, s, e, w);
    return {w, e, s, n, l};
  endfunction

  task automatic add(input logic s, input logic [N*W-1:0] r, input logic [N-1:0] rdy,
                     input logic [W-1:0] p, input logic [N-1:0] g);
    tbl[nvec].srst  = s;
    tbl[nvec].req   = r;
    tbl[nvec].ready = rdy;
    tbl[nvec].pkt   = p;
    tbl[nvec].gnt   = g;
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs away from the clock edge, then sample all outputs before the next edge.
  task automatic cyc(input string nm, input logic s, input logic [N*W-1:0] r,
                     input logic [N-1:0] rdy, input logic [W-1:0] p, input logic [N-1:0] g);
    @(negedge clk);
    srst = s;
    req  = r;
    #1;
    chk({nm, ".ready"},  W'(ready),  W'(rdy));
    chk({nm, ".packet"}, packet,     p);
    chk({nm, ".grant"},  W'(grant),  W'(g));
  endtask

  localparam logic [W-1:0] P0 = 32'h1111_1110, P1 = 32'h2222_2221, P2 = 32'h3333_3332;
  localparam logic [W-1:0] P3 = 32'h4444_4443, P4 = 32'h5555_5554, PN = 32'h0000_0A05;
  localparam logic [W-1:0] PD = 32'hDEAD_BEEF, PB = 32'hB000_0004;
  localparam logic [W-1:0] PC0 = 32'hC000_0000, PC3 = 32'hC000_0003, PE = 32'hE000_0010;

  initial begin
    srst = 1'b1;
    req  = '0;

    add(0, '0,                         5'b11111, '0, 5'b00000);
    add(0, mk(0, PN, 0, 0, 0),         5'b11111, '0, 5'b00000);
    add(0, '0,                         5'b11111, '0, 5'b00000);
    add(0, '0,                         5'b11111, PN, 5'b00010);
    add(1, '0,                         5'b00000, '0, 5'b00000);
    add(0, mk(P0, P1, P2, P3, P4),     5'b11111, '0, 5'b00000);
    add(0, mk(0, 0, PD, 0, 0),         5'b00001, '0, 5'b00000);
    add(0, mk(0, 0, PD, 0, 0),         5'b00011, P0, 5'b00001);
    add(0, mk(0, 0, PD, 0, 0),         5'b00111, P1, 5'b00010);
    add(0, '0,                         5'b01011, P2, 5'b00100);
    add(0, '0,                         5'b11011, P3, 5'b01000);
    add(0, '0,                         5'b11111, P4, 5'b10000);
    add(0, mk(0, 0, 0, 0, PB),         5'b11111, PD, 5'b00100);
    add(0, mk(PC0, 0, 0, PC3, 0),      5'b11111, '0, 5'b00000);
    add(0, '0,                         5'b10111, PB, 5'b10000);
    add(0, '0,                         5'b11111, PC0, 5'b00001);
    add(0, '0,                         5'b11111, PC3, 5'b01000);
    add(0, '0,                         5'b11111, '0, 5'b00000);

    repeat (2) @(posedge clk);
    cyc("reset", 1'b1, '0, 5'b00000, '0, 5'b00000);

    for (int i = 0; i < nvec; i++)
      cyc($sformatf("vec%0d", i), tbl[i].srst, tbl[i].req, tbl[i].ready, tbl[i].pkt, tbl[i].gnt);

    // East streams eight packets back to back; outputs trail acceptance by two samples.
    for (int k = 0; k < 11; k++) begin
      cyc($sformatf("bypass%0d", k), 1'b0,
          (k < 8) ? mk(0, 0, 0, PE + W'(k), 0) : '0,
          5'b11111,
          (k >= 2 && k <= 9) ? PE + W'(k - 2) : '0,
          (k >= 2 && k <= 9) ? 5'b01000 : 5'b00000);
    end

`ifdef NOC_ARB_GRANT_COUNT_EN
    chk("count0", W'(gcount[0*16 +: 16]), 32'd2);
    chk("count1", W'(gcount[1*16 +: 16]), 32'd1);
    chk("count2", W'(gcount[2*16 +: 16]), 32'd2);
    chk("count3", W'(gcount[3*16 +: 16]), 32'd10);
    chk("count4", W'(gcount[4*16 +: 16]), 32'd2);
`endif

    // Three slots loaded, then reset before any of them can be granted.
    cyc("midload",  1'b0, mk(32'hF0, 32'hF1, 32'hF2, 0, 0), 5'b11111, '0, 5'b00000);
    cyc("midreset", 1'b1, '0, 5'b00000, '0, 5'b00000);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("after%0d", k), 1'b0, '0, 5'b11111, '0, 5'b00000);

`ifdef NOC_ARB_GRANT_COUNT_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("cntclr%0d", i), W'(gcount[i*16 +: 16]), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Per-output-port round-robin arbiter for the NoC router. It shares one outgoing link (north, south, east, west or local NI) between the five router inputs: local NI, north, south, east and west. Each input has a one-entry holding register with a ready handshake, so simultaneous packets toward the same output are serialised instead of being ORed together. One instance sits behind each router output register.

## Interface
- `GRID_WIDTH`, default 4: mesh dimension; kept for coordinate width consistency with the router.
- `NUM_REQ`, default 5: number of requesters. Index 0 local, 1 north, 2 south, 3 east, 4 west.
- `APB_PACKET_WIDTH`, localparam = `pa_noc::APB_PACKET_WIDTH`: packet width W.
- `i_clk`  input  1  single clock. All logic is on its rising edge.
- `i_srst`  input  1  reset, synchronous and active-high.
- `i_req`  input  NUM_REQ*W  packed request packets; slot i is bits [i*W +: W]. A nonzero slot means a valid packet; all-zero means idle.
- `o_ready`  output  NUM_REQ  per-input ready. Combinational.
- `o_packet`  output  W  granted packet, registered; all-zero when idle.
- `o_grant`  output  NUM_REQ  one-hot index of the requester driving `o_packet`, registered; zero when idle.

## Operation
- State per input i:
  - `hold[i]` (W bits).
  - `full[i]` (1 bit).
- Shared state: round-robin pointer `ptr`, range 0..NUM_REQ-1.
- Arbitration is combinational from `full` and `ptr` only:
  - `gnt` is the first index j with `full[j]=1`, searching j = ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - `gnt` is empty if no slot is full.
- Ready rule: `o_ready[i] = !i_srst && (!full[i] || gnt==i)`.
  - The slot being granted this cycle can accept a new packet in the same cycle (bypass refill).
- Accept: when `i_req[i]` is nonzero and `o_ready[i]=1`, then at the edge `hold[i]<=i_req[i]` and `full[i]<=1`.
- Upstream contract: a packet presented while `o_ready[i]=0` must be held stable by the sender until ready. The arbiter ignores it and never corrupts `hold[i]`.
- Grant at the edge, when `gnt` is valid:
  - `o_packet<=hold[gnt]`.
  - `o_grant<=onehot(gnt)`.
  - `full[gnt]<=0`, unless refilled in the same cycle.
  - `ptr<=(gnt+1) mod NUM_REQ`. The wrap from 4 goes to 0.
- No grant at the edge: `o_packet<=0`, `o_grant<=0`, `ptr` unchanged.
- Accept and grant on the same slot in the same cycle: `full` stays 1 and `hold` takes the new packet. The old packet goes to `o_packet`.
- The arbiter does not decode or check the packet contents. Route selection (XY) stays in the router; packet bits [3:0] pass through unmodified.

## Timing
- Reset, while `i_srst`=1 at an edge:
  - `full`=0, `ptr`=0, `o_packet`=0, `o_grant`=0. Held packets are discarded.
  - `o_ready`=0 while `i_srst` is high, and all ones in the first cycle after release.
- Latency: a packet accepted at edge E0 appears on `o_packet` after edge E1 at the earliest, which is the minimum. Worst case is E0+NUM_REQ edges, because each of the other four full slots is served once first.
- Throughput: one packet per cycle on the output.
  - A single continuously requesting input sustains 1 packet/cycle through the bypass refill.
- Fairness: with all five slots continuously full, grants rotate 0,1,2,3,4,0,…
  - No input waits more than NUM_REQ-1 grants.
- Reset asserted mid-operation: in-flight packets are lost. `o_packet` is zero from the next cycle.

## Configuration
- Macro `NOC_ARB_GRANT_COUNT_EN`.
- Defined:
  - Adds output `o_grantCount`, NUM_REQ*16 bits. Slot i counts grants to requester i.
  - Each counter increments at the grant edge, clears on `i_srst`, and saturates at 16'hFFFF (no wrap).
- Undefined: the port and the counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset, then idle → `o_packet`=0 and `o_grant`=0 every cycle; `o_ready`=5'b11111 one cycle after `i_srst` drops and 5'b00000 during reset.
- Single input: north presents 0x…5 for one cycle → `o_ready[1]`=1 and the packet is accepted. `o_packet`=0x…5 with `o_grant`=5'b00010 one cycle later, then 0 the next cycle.
- All five present distinct nonzero packets in the same cycle and hold until ready, with `ptr`=0 → outputs in order local, N, S, E, W on five consecutive cycles. `o_grant` walks 00001→10000, and `o_ready[i]` stays low until slot i is granted.
- Wrap-around: after a west grant (`ptr`=0), local and east both full → local is granted first, then east.
- Bypass: east streams a new nonzero packet every cycle for 8 cycles with no other traffic → 8 back-to-back outputs, `o_ready[3]` constantly 1, no bubbles.
- Reset mid-burst: three slots full, assert `i_srst` for one cycle → `o_packet`=0 next cycle, no held packet ever emitted. With `NOC_ARB_GRANT_COUNT_EN` defined, all counts read 0.
